// File: rtl/alu_ram_top_if.sv
// Operand/opcode/write bus of the register-file ALU tile, plus its registered result and flags.
interface alu_ram_top_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 3
);
  logic [DATA_W-1:0] data;
  logic              write_enable;
  logic [ADDR_W-1:0] addr_write;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [SEL_W-1:0]  select;
  logic [DATA_W-1:0] result;
  logic              zero_flag;
  logic              carry_flag;

  modport master (
    output data, write_enable, addr_write, addr0, addr1, select,
    input  result, zero_flag, carry_flag
  );

  modport slave (
    input  data, write_enable, addr_write, addr0, addr1, select,
    output result, zero_flag, carry_flag
  );
endinterface

// File: rtl/alu_ram_top.sv
// Compute slice: 16x8 register file with two async read ports feeding an 8-bit ALU
// whose result and flags are registered. Writes land after the output register samples.
module alu_ram_top #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 3
) (
  input logic          clock,
  input logic          reset,
  alu_ram_top_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [SEL_W-1:0] OP_ADD = 3'd0;
  localparam logic [SEL_W-1:0] OP_SUB = 3'd1;
  localparam logic [SEL_W-1:0] OP_AND = 3'd2;
  localparam logic [SEL_W-1:0] OP_OR  = 3'd3;
  localparam logic [SEL_W-1:0] OP_XOR = 3'd4;
  localparam logic [SEL_W-1:0] OP_NOT = 3'd5;
  localparam logic [SEL_W-1:0] OP_SHL = 3'd6;
  localparam logic [SEL_W-1:0] OP_SHR = 3'd7;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   alu_out;  // {carry, res}

  assign op_a = mem[bus.addr0];
  assign op_b = mem[bus.addr1];

  always_comb begin
    alu_out = '0;
    case (bus.select)
      OP_ADD:  alu_out = {1'b0, op_a} + {1'b0, op_b};
      // Bit 8 of the widened difference is the borrow.
      OP_SUB:  alu_out = {1'b0, op_a} - {1'b0, op_b};
      OP_AND:  alu_out = {1'b0, op_a & op_b};
      OP_OR:   alu_out = {1'b0, op_a | op_b};
      OP_XOR:  alu_out = {1'b0, op_a ^ op_b};
      OP_NOT:  alu_out = {1'b0, ~op_a};
      OP_SHL:  alu_out = {op_a, 1'b0};
      OP_SHR:  alu_out = {op_a[0], 1'b0, op_a[DATA_W-1:1]};
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.write_enable) begin
      mem[bus.addr_write] <= bus.data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.result     <= '0;
      bus.zero_flag  <= 1'b1;
      bus.carry_flag <= 1'b0;
    end else begin
      bus.result     <= alu_out[DATA_W-1:0];
      bus.zero_flag  <= (alu_out[DATA_W-1:0] == '0);
      bus.carry_flag <= alu_out[DATA_W];
    end
  end
endmodule

// File: tb/tb_alu_ram_top.sv
// Self-checking bench for alu_ram_top: directed steps plus random traffic against an array-based model.
module tb_alu_ram_top;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   ref_mem [16];
  int   exp_res;
  int   exp_carry;

  alu_ram_top_if bus_if ();

  alu_ram_top dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Plain-arithmetic ALU reference.
  task automatic alu_model(input int sel, input int a, input int b, output int res, output int cy);
    int s;
    case (sel)
      0: begin s = a + b; res = s % 256; cy = (s > 255) ? 1 : 0; end
      1: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
      2: begin res = a & b; cy = 0; end
      3: begin res = a | b; cy = 0; end
      4: begin res = a ^ b; cy = 0; end
      5: begin res = 255 - a; cy = 0; end
      6: begin res = (a * 2) % 256; cy = (a >= 128) ? 1 : 0; end
      default: begin res = a / 2; cy = a % 2; end
    endcase
  endtask

  // Drive one cycle, predict from pre-write contents, then retire the write in the model.
  task automatic step(input string tag, input int we, input int aw, input int d,
                      input int a0, input int a1, input int sel);
    int r, c;
    bus_if.write_enable = we[0];
    bus_if.addr_write   = aw[3:0];
    bus_if.data         = d[7:0];
    bus_if.addr0        = a0[3:0];
    bus_if.addr1        = a1[3:0];
    bus_if.select       = sel[2:0];
    alu_model(sel, ref_mem[a0], ref_mem[a1], r, c);
    if (we != 0) ref_mem[aw] = d;
    @(posedge clock);
    #1;
    exp_res   = r;
    exp_carry = c;
    chk({tag, ".result"}, int'(bus_if.result), r);
    chk({tag, ".zero"},   int'(bus_if.zero_flag), (r == 0) ? 1 : 0);
    chk({tag, ".carry"},  int'(bus_if.carry_flag), c);
  endtask

  task automatic do_reset(input string tag, input int we);
    reset = 1'b1;
    bus_if.write_enable = we[0];
    bus_if.addr_write   = 4'd4;
    bus_if.data         = 8'hA5;
    @(posedge clock);
    #1;
    foreach (ref_mem[i]) ref_mem[i] = 0;
    chk({tag, ".result"}, int'(bus_if.result), 0);
    chk({tag, ".zero"},   int'(bus_if.zero_flag), 1);
    chk({tag, ".carry"},  int'(bus_if.carry_flag), 0);
    reset = 1'b0;
    bus_if.write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus_if.write_enable = 1'b0;
    bus_if.addr_write = '0;
    bus_if.data = '0;
    bus_if.addr0 = '0;
    bus_if.addr1 = '0;
    bus_if.select = '0;
    foreach (ref_mem[i]) ref_mem[i] = 0;
    @(posedge clock);
    #1;
    do_reset("rst0", 0);

    step("wr1", 1, 1, 100, 0, 0, 0);
    step("wr2", 1, 2, 50,  0, 0, 0);
    step("wr3", 1, 3, 150, 0, 0, 0);
    step("wr4", 1, 4, 250, 0, 0, 0);

    step("add", 0, 0, 0, 4, 2, 0);
    chk("spec_add", int'(bus_if.result), 44);
    chk("spec_add_c", int'(bus_if.carry_flag), 1);
    step("sub", 0, 0, 0, 4, 2, 1);
    chk("spec_sub", int'(bus_if.result), 200);
    step("and", 0, 0, 0, 4, 2, 2);
    chk("spec_and", int'(bus_if.result), 50);
    step("or",  0, 0, 0, 4, 2, 3);
    chk("spec_or", int'(bus_if.result), 250);
    step("xor", 0, 0, 0, 4, 2, 4);
    chk("spec_xor", int'(bus_if.result), 200);
    step("sub_eq", 0, 0, 0, 2, 2, 1);
    chk("spec_sub_eq_z", int'(bus_if.zero_flag), 1);
    step("sub_brw", 0, 0, 0, 2, 4, 1);
    chk("spec_sub_brw", int'(bus_if.result), 56);
    chk("spec_sub_brw_c", int'(bus_if.carry_flag), 1);
    step("shl", 0, 0, 0, 4, 4, 6);
    chk("spec_shl", int'(bus_if.result), 244);
    step("shr", 0, 0, 0, 4, 4, 7);
    chk("spec_shr", int'(bus_if.result), 125);
    step("not", 0, 0, 0, 4, 4, 5);
    chk("spec_not", int'(bus_if.result), 5);

    // Same-edge write/read: old value first, new value one edge later.
    step("wr_old", 1, 4, 7, 4, 4, 3);
    chk("spec_wr_old", int'(bus_if.result), 250);
    step("wr_new", 0, 0, 0, 4, 4, 3);
    chk("spec_wr_new", int'(bus_if.result), 7);

    // Edge values of the address space.
    step("wr0",  1, 0,  8'hFF, 0, 0, 0);
    step("wr15", 1, 15, 8'h01, 0, 15, 0);
    step("e_add", 0, 0, 0, 0, 15, 0);
    chk("spec_wrap_zero", int'(bus_if.zero_flag), 1);

    for (int n = 0; n < 300; n++) begin
      step("rnd", int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    end

    // Reset wins over a concurrent write; afterwards every entry reads 0.
    step("pre_rst", 0, 0, 0, 4, 4, 3);
    do_reset("rst1", 1);
    for (int a = 0; a < 16; a++) begin
      step("mem_clr", 0, 0, 0, a, a, 3);
      chk("mem_clr_val", int'(bus_if.result), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
